bike_bram_streamer: RTL and testbench
=====================================

BIKE_BRAM_STREAMER -- requirements
Module: bike_bram_streamer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter C, default 2, SHALL give the number of 1024x32 BRAMs behind port A; AW = clog2(C)+10; DEPTH = C*1024.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port start, input, 1, command strobe, sampled only in IDLE.
REQ-006 Port mode, input, 1, command type: 0 = load (stream to memory), 1 = unload (memory to stream).
REQ-007 Port base_addr, input, AW, first word address.
REQ-008 Port len, input, AW+1, word count, 0..DEPTH.
REQ-009 Port busy, output, 1, high while a command is active.
REQ-010 Port done, output, 1, one-cycle pulse at command completion.
REQ-011 Ports s_din, s_valid, s_ready: input 32, input 1, output 1; load stream sink.
REQ-012 Ports m_dout, m_valid, m_ready: output 32, output 1, input 1; unload stream source.
REQ-013 Ports mem_wen, mem_ren, mem_addr, mem_din: output 1, output 1, output AW, output 32; drive concatenated-memory port A.
REQ-014 Port mem_dout, input, 32; port A read data, valid exactly 1 cycle after mem_ren.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, UNLOAD, FIN; FIN lasts one cycle, asserts done, then returns to IDLE.
REQ-016 IDLE + start + len=0 SHALL go to FIN with no memory access.
REQ-017 IDLE + start + len>0 SHALL latch base_addr, len, mode and enter LOAD (mode 0) or UNLOAD (mode 1) next cycle; busy high from that cycle through FIN.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 LOAD: s_ready=1 while fewer than len words have been accepted; each cycle with s_valid&s_ready SHALL assert mem_wen with mem_din=s_din and mem_addr=(base+k) mod DEPTH, k = words accepted so far.
REQ-020 LOAD SHALL enter FIN the cycle after the len-th accepted word; s_ready=0 outside LOAD.
REQ-021 UNLOAD: mem_ren SHALL pulse for addresses (base+k) mod DEPTH, k=0..len-1, in order, each address issued exactly once.
REQ-022 UNLOAD SHALL hold a 2-entry output FIFO; a read SHALL be issued only if FIFO occupancy plus in-flight reads is less than 2, so no word is lost under m_ready=0.
REQ-023 m_valid SHALL be high whenever the FIFO is non-empty; a word is consumed when m_valid&m_ready; output order equals address order.
REQ-024 With m_ready held high, UNLOAD SHALL sustain one word per cycle; first m_valid SHALL occur 2 cycles after entering UNLOAD.
REQ-025 UNLOAD SHALL enter FIN the cycle after the len-th word is consumed.
REQ-026 mem_wen and mem_ren SHALL never be asserted in the same cycle; both are 0 in IDLE and FIN.
REQ-027 Address arithmetic SHALL wrap modulo DEPTH: base=DEPTH-1 is followed by address 0.

Reset
REQ-028 reset SHALL immediately force IDLE, FIFO empty, counters 0, busy=0, done=0, s_ready=0, m_valid=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_din=0, m_dout=0.
REQ-029 reset mid-command SHALL abort without a done pulse; an in-flight read's data SHALL be discarded.

Configuration
REQ-030 Macro BIKE_STREAMER_BSWAP_EN defined: s_din is byte-reversed before mem_din and mem_dout is byte-reversed before m_dout.
REQ-031 Macro undefined: data SHALL pass unmodified in both directions.

Verification
REQ-032 Load base=0x010, len=3, s_din 0xA0,0xA1,0xA2 with s_valid held high -> mem_wen on 3 consecutive cycles at 0x010..0x012, done one cycle later.
REQ-033 Unload base=0x010, len=3, m_ready=1 -> m_dout 0xA0,0xA1,0xA2 on consecutive cycles, first word 2 cycles after entering UNLOAD.
REQ-034 Unload len=8, m_ready toggling 1,0,0,1,... -> all 8 words delivered in order, never more than 2 reads outstanding or buffered.
REQ-035 C=2, load base=0x7FE, len=4 -> writes to 0x7FE, 0x7FF, 0x000, 0x001.
REQ-036 start with len=0 -> done 1 cycle later, no mem_wen or mem_ren; a second start while busy -> ignored.
REQ-037 reset asserted mid-unload after 2 of 5 words -> busy=0 immediately, no done, next command runs correctly; with BIKE_STREAMER_BSWAP_EN, a load of 0x11223344 writes 0x44332211.

Source files
------------

// File: rtl/bike_bram_streamer_if.sv
// Command, stream and memory-port bundle for bike_bram_streamer.
// slave: the streamer side; master: the side that drives commands, streams and memory data.
interface bike_bram_streamer_if #(
    parameter int unsigned AW = 11
);
    logic          start;
    logic          mode;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [31:0]   s_din;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   m_dout;
    logic          m_valid;
    logic          m_ready;
    logic          mem_wen;
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    modport slave (
        input  start, mode, base_addr, len, s_din, s_valid, m_ready, mem_dout,
        output busy, done, s_ready, m_dout, m_valid, mem_wen, mem_ren, mem_addr, mem_din
    );

    modport master (
        output start, mode, base_addr, len, s_din, s_valid, m_ready, mem_dout,
        input  busy, done, s_ready, m_dout, m_valid, mem_wen, mem_ren, mem_addr, mem_din
    );
endinterface

// File: rtl/bike_bram_streamer.sv
// Streams words between a valid/ready stream and a concatenated BRAM port (load / unload).
// Define BIKE_STREAMER_BSWAP_EN to byte-reverse data in both directions.
module bike_bram_streamer #(
    parameter int unsigned C = 2
) (
    input  logic                clk,
    input  logic                reset,
    bike_bram_streamer_if.slave bus
);
    localparam int unsigned AW = $clog2(C) + 10;
    localparam int unsigned DEPTH = C * 1024;
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StUnload, StFin} state_e;

    function automatic logic [31:0] swap32(input logic [31:0] d);
`ifdef BIKE_STREAMER_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   out_cnt_q, out_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    occ_q, occ_d;
    logic [31:0]   fifo0_q, fifo0_d;
    logic [31:0]   fifo1_q, fifo1_d;
    logic          s_ready_q, s_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          wen, ren, pop;
    logic [1:0]    occ_after_pop;
    logic [2:0]    credit_used;
    logic [AW:0]   cnt_inc, out_cnt_inc;
    logic [AW-1:0] addr_inc;

    assign cnt_inc     = cnt_q + {{AW{1'b0}}, 1'b1};
    assign out_cnt_inc = out_cnt_q + {{AW{1'b0}}, 1'b1};
    assign addr_inc    = (addr_q == LastAddr) ? '0 : addr_q + {{(AW-1){1'b0}}, 1'b1};

    always_comb begin
        wen           = (state_q == StLoad) && bus.s_valid && s_ready_q;
        pop           = (occ_q != 2'd0) && bus.m_ready;
        occ_after_pop = occ_q - {1'b0, pop};
        // A word leaving the FIFO this cycle frees its slot for a new read, sustaining 1 word/cycle.
        credit_used   = {1'b0, occ_after_pop} + {2'b00, inflight_q};
        ren           = (state_q == StUnload) && (cnt_q < len_q) && (credit_used < 3'd2);
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        out_cnt_d  = out_cnt_q;
        addr_d     = addr_q;
        s_ready_d  = s_ready_q;
        inflight_d = ren;
        occ_d      = occ_after_pop + {1'b0, inflight_q};
        fifo0_d    = fifo0_q;
        fifo1_d    = fifo1_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    len_d     = bus.len;
                    addr_d    = bus.base_addr;
                    cnt_d     = '0;
                    out_cnt_d = '0;
                    if (bus.len == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d   = bus.mode ? StUnload : StLoad;
                        s_ready_d = ~bus.mode;
                    end
                end
            end
            StLoad: begin
                if (wen) begin
                    addr_d = addr_inc;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) begin
                        s_ready_d = 1'b0;
                        state_d   = StFin;
                    end
                end
            end
            StUnload: begin
                if (ren) begin
                    addr_d = addr_inc;
                    cnt_d  = cnt_inc;
                end
                if (pop) begin
                    out_cnt_d = out_cnt_inc;
                    if (out_cnt_inc == len_q) state_d = StFin;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (pop) fifo0_d = fifo1_q;
        if (inflight_q) begin
            if (occ_after_pop == 2'd0) fifo0_d = swap32(bus.mem_dout);
            else                       fifo1_d = swap32(bus.mem_dout);
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StFin);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            out_cnt_q  <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            fifo0_q    <= '0;
            fifo1_q    <= '0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            out_cnt_q  <= out_cnt_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            fifo0_q    <= fifo0_d;
            fifo1_q    <= fifo1_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.s_ready  = s_ready_q;
    assign bus.m_valid  = (occ_q != 2'd0);
    assign bus.m_dout   = fifo0_q;
    assign bus.mem_wen  = wen;
    assign bus.mem_ren  = ren;
    assign bus.mem_addr = (wen || ren) ? addr_q : '0;
    assign bus.mem_din  = wen ? swap32(bus.s_din) : '0;

endmodule

// File: tb/tb_bike_bram_streamer.sv
// Randomized scoreboard bench for bike_bram_streamer: a plain array stands in for the memory
// contents and expected writes / reads / output words are queued per command.
module tb_bike_bram_streamer;
    localparam int C = 2;
    localparam int AW = 11;
    localparam int DEPTH = 2048;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    bike_bram_streamer_if #(.AW(AW)) bus ();

    bike_bram_streamer #(.C(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] bram    [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] mem_rd = '0;

    always @(posedge clk) begin
        if (bus.mem_wen) bram[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_ren) mem_rd <= bram[bus.mem_addr];
    end
    assign bus.mem_dout = mem_rd;

    int vectors = 0;
    int miscompares = 0;

    wr_t         wr_q[$];
    logic [AW-1:0] ra_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] fixed_words[$];
    int          wen_cyc[$];
    int          pop_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          issued = 0;
    int          consumed = 0;

    function automatic logic [31:0] tb_swap(input logic [31:0] d);
`ifdef BIKE_STREAMER_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int act);
        vectors++;
        miscompares++;
        $display("FAIL %s: observed %0d, none expected (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write, a read or an output word.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_wen && bus.mem_ren) flag("wen_ren_overlap", 1);
            if (bus.mem_wen) begin
                wen_cyc.push_back(cyc);
                if (wr_q.size() == 0) flag("unexpected_write", int'(bus.mem_addr));
                else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
                    chk("wr_data", 64'(bus.mem_din), 64'(e.data));
                end
            end
            if (bus.mem_ren) begin
                issued++;
                if (ra_q.size() == 0) flag("unexpected_read", int'(bus.mem_addr));
                else chk("rd_addr", 64'(bus.mem_addr), 64'(ra_q.pop_front()));
            end
            if (bus.m_valid && bus.m_ready) begin
                consumed++;
                pop_cyc.push_back(cyc);
                if (rd_q.size() == 0) flag("unexpected_word", int'(bus.m_dout));
                else chk("m_dout", 64'(bus.m_dout), 64'(rd_q.pop_front()));
            end
            if (bus.mem_ren) begin
                vectors++;
                if (issued - consumed > 2) begin
                    miscompares++;
                    $display("FAIL outstanding: got %0d, required <= 2", issued - consumed);
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // vmode: 0 = valid/ready held high, 1 = pattern 1,0,0 repeating, 2 = random.
    task automatic run_cmd(input bit m, input int base, input int n, input int vmode,
                           input bit junk_start, input int abort_after, output int enter);
        logic [31:0] words[$];
        int d0, idx, budget;
        bit acc, aborted;
        d0 = done_cnt;
        aborted = 1'b0;
        issued = 0;
        consumed = 0;
        wen_cyc.delete();
        pop_cyc.delete();
        for (int k = 0; k < n; k++) begin
            int a;
            a = (base + k) % DEPTH;
            if (!m) begin
                logic [31:0] w;
                w = (fixed_words.size() != 0) ? fixed_words.pop_front() : $urandom;
                words.push_back(w);
                wr_q.push_back('{addr: AW'(a), data: tb_swap(w)});
                ref_mem[a] = tb_swap(w);
            end else begin
                ra_q.push_back(AW'(a));
                rd_q.push_back(tb_swap(ref_mem[a]));
            end
        end
        bus.start = 1'b1;
        bus.mode = m;
        bus.base_addr = AW'(base);
        bus.len = (AW + 1)'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len = (AW + 1)'($urandom_range(1, 9));
        enter = cyc;
        if (n > 0) chk("busy_on_entry", 64'(bus.busy), 64'(1));
        if (n > 0 && !m) begin
            idx = 0;
            budget = 0;
            while (idx < n && budget < 500) begin
                bus.s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (budget % 3 == 0) :
                              1'($urandom_range(0, 1));
                bus.s_din = words[idx];
                bus.start = junk_start && (budget == 1);
                bus.mode = 1'b1;
                @(negedge clk);
                acc = bus.s_valid && bus.s_ready;
                @(posedge clk); #1;
                budget++;
                if (acc) idx++;
            end
            bus.s_valid = 1'b0;
            bus.start = 1'b0;
            bus.s_din = $urandom;
        end else if (n > 0) begin
            budget = 0;
            while (done_cnt == d0 && budget < 500) begin
                bus.m_ready = (vmode == 0) ? 1'b1 : (vmode == 1) ? (budget % 3 == 0) :
                              1'($urandom_range(0, 1));
                @(posedge clk); #1;
                budget++;
                if (abort_after > 0 && consumed >= abort_after) begin
                    reset = 1'b1;
                    #1;
                    chk("abort_busy", 64'(bus.busy), 64'(0));
                    chk("abort_m_valid", 64'(bus.m_valid), 64'(0));
                    chk("abort_mem_ren", 64'(bus.mem_ren), 64'(0));
                    chk("abort_done", 64'(bus.done), 64'(0));
                    ra_q.delete();
                    rd_q.delete();
                    repeat (2) @(posedge clk);
                    #1 reset = 1'b0;
                    aborted = 1'b1;
                    break;
                end
            end
            bus.m_ready = 1'b0;
        end
        if (aborted) begin
            chk("abort_no_done_pulse", 64'(done_cnt - d0), 64'(0));
        end else begin
            budget = 0;
            while (done_cnt == d0 && budget < 500) begin
                @(posedge clk); #1;
                budget++;
            end
            chk("done_pulses", 64'(done_cnt - d0), 64'(1));
            chk("idle_after_done", 64'(bus.busy), 64'(0));
        end
        chk("writes_left", 64'(wr_q.size()), 64'(0));
        chk("reads_left", 64'(ra_q.size()), 64'(0));
        chk("words_left", 64'(rd_q.size()), 64'(0));
        wr_q.delete();
        ra_q.delete();
        rd_q.delete();
    endtask

    initial begin
        int e;
        for (int i = 0; i < DEPTH; i++) begin
            bram[i] = $urandom;
            ref_mem[i] = bram[i];
        end
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.base_addr = '0;
        bus.len = '0;
        bus.s_din = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_s_ready", 64'(bus.s_ready), 64'(0));
        chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
        chk("rst_mem_wen", 64'(bus.mem_wen), 64'(0));
        chk("rst_mem_ren", 64'(bus.mem_ren), 64'(0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_mem_din", 64'(bus.mem_din), 64'(0));
        chk("rst_m_dout", 64'(bus.m_dout), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Load 3 words at 0x010 with s_valid held: back-to-back writes, done right after.
        fixed_words.push_back(32'hA0);
        fixed_words.push_back(32'hA1);
        fixed_words.push_back(32'hA2);
        run_cmd(1'b0, 'h010, 3, 0, 1'b0, 0, e);
        chk("load_wr_count", 64'(wen_cyc.size()), 64'(3));
        for (int i = 0; i < 3 && i < wen_cyc.size(); i++) chk("load_wr_cycle", 64'(wen_cyc[i]), 64'(e + i));
        chk("load_done_cycle", 64'(done_cyc), 64'(e + 3));

        // Unload the same words with m_ready held: first word 2 cycles after entry.
        run_cmd(1'b1, 'h010, 3, 0, 1'b0, 0, e);
        chk("unload_word_count", 64'(pop_cyc.size()), 64'(3));
        for (int i = 0; i < 3 && i < pop_cyc.size(); i++) chk("unload_word_cycle", 64'(pop_cyc[i]), 64'(e + 2 + i));
        chk("unload_done_cycle", 64'(done_cyc), 64'(e + 5));

        // Backpressure 1,0,0 on an 8-word unload.
        run_cmd(1'b1, 'h100, 8, 1, 1'b0, 0, e);
        chk("bp_word_count", 64'(pop_cyc.size()), 64'(8));

        // Wrap at the top of the address space.
        run_cmd(1'b0, 'h7FE, 4, 2, 1'b0, 0, e);
        run_cmd(1'b1, 'h7FE, 4, 2, 1'b0, 0, e);

        // Zero-length command completes in one cycle with no memory traffic.
        run_cmd(1'b0, 'h055, 0, 0, 1'b0, 0, e);
        chk("len0_done_cycle", 64'(done_cyc), 64'(e));

        // A start pulse in the middle of a load must be ignored.
        run_cmd(1'b0, 'h200, 4, 2, 1'b1, 0, e);

        // Reset after 2 of 5 unloaded words, then a clean unload.
        run_cmd(1'b1, 'h300, 5, 0, 1'b0, 2, e);
        run_cmd(1'b1, 'h300, 5, 0, 1'b0, 0, e);

        // Data-order check on a known word.
        fixed_words.push_back(32'h11223344);
        run_cmd(1'b0, 'h040, 1, 0, 1'b0, 0, e);
`ifdef BIKE_STREAMER_BSWAP_EN
        chk("bswap_word", 64'(bram['h040]), 64'(32'h44332211));
`else
        chk("bswap_word", 64'(bram['h040]), 64'(32'h11223344));
`endif
        run_cmd(1'b1, 'h040, 1, 0, 1'b0, 0, e);

        for (int t = 0; t < 30; t++) begin
            int base;
            base = ($urandom_range(0, 3) == 0) ? DEPTH - $urandom_range(1, 6) :
                   $urandom_range(0, DEPTH - 1);
            run_cmd(1'($urandom_range(0, 1)), base, $urandom_range(0, 12), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), 0, e);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
